// File: rtl/ase_emul_ooo_rsp_scheduler_pkg.sv
// Shared types, LFSR constants and small helpers for the ASE out-of-order response scheduler.
// Types are sized for the largest supported buffer (16 slots); users mask to their own depth.
package ase_emul_ooo_pkg;

  localparam int N_ENTRIES_MAX = 16;
  localparam int LFSR_W        = 20;
  // Galois right-shift mask for x^20 + x^17 + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 20'h90000;

  typedef logic [$clog2(N_ENTRIES_MAX)-1:0] t_slot_idx;
  typedef logic [$clog2(N_ENTRIES_MAX):0]   t_seq;
  typedef logic [7:0]                       t_age;
  typedef logic [LFSR_W-1:0]                t_lfsr;

  function automatic t_lfsr lfsr20_next(input t_lfsr s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Sequence numbers wrap modulo 2*N so head/tail stay unambiguous with N in flight.
  function automatic t_seq seq_next(input t_seq s, input int n_entries);
    t_seq mask;
    mask = t_seq'(2 * n_entries - 1);
    return (s + t_seq'(1)) & mask;
  endfunction

endpackage

// File: rtl/ase_emul_ooo_rsp_scheduler_if.sv
// Valid/ready response stream; the scheduler is a slave on its input and a master on its output.
interface ase_emul_ooo_rsp_scheduler_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ase_emul_ooo_rsp_scheduler_lfsr20.sv
// Free-running 20-bit Galois LFSR that drives the pseudo-random release decisions.
module ase_emul_ooo_lfsr20
  import ase_emul_ooo_pkg::*;
#(
  parameter t_lfsr SEED = 20'h8676d
) (
  input  logic  clk,
  input  logic  reset_n,
  output t_lfsr state
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= SEED;
    else          state <= lfsr20_next(state);
  end

endmodule

// File: rtl/ase_emul_ooo_rsp_scheduler.sv
// Response reorder buffer: holds up to N_ENTRIES responses and releases them either in arrival
// order or pseudo-randomly with an age-based starvation bound, through one output register.
module ase_emul_ooo_rsp_scheduler
  import ase_emul_ooo_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          N_ENTRIES  = 4,
  parameter int          MAX_AGE    = 15,
  parameter logic [19:0] LFSR_SEED  = 20'h8676d
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ooo_en,
  ase_emul_ooo_rsp_scheduler_if.slave   rsp_in,
  ase_emul_ooo_rsp_scheduler_if.master  rsp_out,
  output logic [$clog2(N_ENTRIES)+1:0]  occupancy
);

  localparam int   IDX_W   = $clog2(N_ENTRIES);
  localparam int   OCC_W   = IDX_W + 2;
  localparam t_age AGE_MAX = t_age'(MAX_AGE);

  logic [N_ENTRIES-1:0]  slot_valid, slot_valid_nxt;
  t_seq                  slot_seq  [N_ENTRIES];
  t_age                  slot_age  [N_ENTRIES];
  logic [DATA_WIDTH-1:0] slot_data [N_ENTRIES];

  t_seq                  head_seq, tail_seq;
  logic                  mode_ooo;
  logic                  out_valid_q, out_valid_nxt;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [OCC_W-1:0]      occupancy_nxt;
  t_lfsr                 lfsr;
  logic                  unused_lfsr_hi;

  logic                  full, accept, out_free, sel_valid, release_slot;
  logic                  aged_hit, rot_hit;
  logic [IDX_W-1:0]      free_idx, sel_idx, aged_idx, rot_idx, rot_probe;

  ase_emul_ooo_lfsr20 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (lfsr)
  );
  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:IDX_W];

  assign full         = &slot_valid;
  assign rsp_in.ready = !full;
  assign accept       = rsp_in.valid && !full;
  assign out_free     = !out_valid_q || rsp_out.ready;
  assign release_slot = sel_valid && out_free;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    free_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!slot_valid[i]) free_idx = IDX_W'(i);
    end
  end

  // Downward scans leave the lowest index (or the first slot after the LFSR start) selected.
  always_comb begin
    aged_hit  = 1'b0;
    aged_idx  = '0;
    rot_hit   = 1'b0;
    rot_idx   = '0;
    rot_probe = '0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (slot_valid[i] && slot_age[i] == AGE_MAX) begin
        aged_hit = 1'b1;
        aged_idx = IDX_W'(i);
      end
    end
    for (int k = N_ENTRIES - 1; k >= 0; k--) begin
      rot_probe = lfsr[IDX_W-1:0] + IDX_W'(k);
      if (slot_valid[rot_probe]) begin
        rot_hit = 1'b1;
        rot_idx = rot_probe;
      end
    end
    if (mode_ooo) begin
      if (aged_hit) begin
        sel_valid = 1'b1;
        sel_idx   = aged_idx;
      end else if (rot_hit && (lfsr[0] || full)) begin
        sel_valid = 1'b1;
        sel_idx   = rot_idx;
      end
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (slot_valid[i] && slot_seq[i] == head_seq) begin
          sel_valid = 1'b1;
          sel_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Free and fill never collide: the released slot is valid, the filled one is not.
  always_comb begin
    slot_valid_nxt = slot_valid;
    if (release_slot) slot_valid_nxt[sel_idx]  = 1'b0;
    if (accept)       slot_valid_nxt[free_idx] = 1'b1;
    out_valid_nxt = out_free ? sel_valid : out_valid_q;
    occupancy_nxt = OCC_W'(out_valid_nxt);
    for (int i = 0; i < N_ENTRIES; i++) begin
      occupancy_nxt = occupancy_nxt + OCC_W'(slot_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_valid  <= '0;
      out_valid_q <= 1'b0;
      occupancy   <= '0;
      head_seq    <= '0;
      tail_seq    <= '0;
      mode_ooo    <= 1'b0;
    end else begin
      slot_valid  <= slot_valid_nxt;
      out_valid_q <= out_valid_nxt;
      occupancy   <= occupancy_nxt;
      if (release_slot) head_seq <= seq_next(head_seq, N_ENTRIES);
      if (accept)       tail_seq <= seq_next(tail_seq, N_ENTRIES);
      // Mode only changes while nothing is in flight, so a drain finishes in its original order.
      if (slot_valid == '0 && !out_valid_q) mode_ooo <= ooo_en;
    end
  end

  // NOTE: payload, tag and age storage is not reset; it is only read behind a set slot_valid bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (accept && free_idx == IDX_W'(i)) begin
        slot_data[i] <= rsp_in.data;
        slot_seq[i]  <= tail_seq;
        slot_age[i]  <= '0;
      end else if (slot_valid[i] && slot_age[i] != AGE_MAX) begin
        slot_age[i]  <= slot_age[i] + t_age'(1);
      end
    end
    if (release_slot) out_data_q <= slot_data[sel_idx];
  end

  assign rsp_out.valid = out_valid_q;
  assign rsp_out.data  = out_data_q;

endmodule

// File: tb/tb_ase_emul_ooo_rsp_scheduler.sv
// Directed + random bench: a multiset scoreboard of accepted payloads checks every release,
// with in-order, residency, occupancy and ready expectations derived from buffer contents.
module tb_ase_emul_ooo_rsp_scheduler;

  localparam int DW        = 64;
  localparam int N_ENTRIES = 4;
  localparam int MAX_AGE   = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ooo_en;
  logic [3:0] occupancy;

  ase_emul_ooo_rsp_scheduler_if #(.DATA_WIDTH(DW)) in_if ();
  ase_emul_ooo_rsp_scheduler_if #(.DATA_WIDTH(DW)) out_if ();

  ase_emul_ooo_rsp_scheduler #(
    .DATA_WIDTH (DW),
    .N_ENTRIES  (N_ENTRIES),
    .MAX_AGE    (MAX_AGE),
    .LFSR_SEED  (20'h8676d)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ooo_en    (ooo_en),
    .rsp_in    (in_if.slave),
    .rsp_out   (out_if.master),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard: payloads accepted but not yet moved into the output register, oldest first.
  logic [DW-1:0] outstanding[$];
  int            acc_cyc [bit [DW-1:0]];
  int            acc_blk [bit [DW-1:0]];
  int            cyc = 0;
  int            blk_cnt = 0;
  int            held = 0;
  int            n_loads = 0;
  int            n_reorder = 0;
  int            first_load_step = -1;
  bit            chk_inorder = 1'b0;
  bit            chk_res = 1'b0;
  logic          last_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic process_load(input logic [DW-1:0] d, input int s);
    int idx;
    int res;
    idx = -1;
    foreach (outstanding[i]) if (idx < 0 && outstanding[i] == d) idx = i;
    n_loads++;
    if (first_load_step < 0) first_load_step = s;
    check("release_known_once", 64'(idx >= 0), 64'd1);
    if (idx >= 0) begin
      if (chk_inorder) check("inorder_head", d, outstanding[0]);
      if (idx != 0) n_reorder++;
      if (chk_res) begin
        res = (s - acc_cyc[d]) - (blk_cnt - acc_blk[d]);
        check("residency_in_bound", 64'(res <= MAX_AGE + N_ENTRIES), 64'd1);
      end
      outstanding.delete(idx);
    end
  endtask

  // One clock: drive at negedge, note handshakes, advance, then inspect the new state.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy);
    int   s;
    logic pre_ov, blocked, consumed;
    s = cyc;
    in_if.valid  = iv;
    in_if.data   = id;
    out_if.ready = ordy;
    #1;
    last_acc = iv && (in_if.ready === 1'b1);
    pre_ov   = (out_if.valid === 1'b1);
    blocked  = pre_ov && !ordy;
    consumed = pre_ov && ordy;
    if (blocked) blk_cnt++;
    if (last_acc) begin
      outstanding.push_back(id);
      acc_cyc[id] = s;
      acc_blk[id] = blk_cnt;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (out_if.valid === 1'b1 && (!pre_ov || ordy)) begin
      held = 1;
      process_load(out_if.data, s);
    end else if (consumed) begin
      held = 0;
    end
    check("in_ready", 64'(in_if.ready), 64'(outstanding.size() < N_ENTRIES));
    check("occupancy", 64'(occupancy), 64'(outstanding.size() + held));
  endtask

  task automatic push(input string tag, input logic [DW-1:0] d, input logic ordy);
    int n;
    n = 0;
    do begin
      step(1'b1, d, ordy);
      n++;
    end while (!last_acc && n < 60);
    check(tag, 64'(last_acc), 64'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((outstanding.size() != 0 || held != 0) && n < 400) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    check(tag, 64'(outstanding.size() == 0 && held == 0), 64'd1);
  endtask

  task automatic wait_out_valid(input string tag);
    int n;
    n = 0;
    while (out_if.valid !== 1'b1 && n < 60) begin
      step(1'b0, '0, 1'b0);
      n++;
    end
    check(tag, 64'(out_if.valid), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            sent;
    int            n;
    logic [DW-1:0] saved_d;
    logic [3:0]    saved_occ;
    logic          acc6;

    reset_n      = 1'b0;
    ooo_en       = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_out_valid", 64'(out_if.valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_in_ready", 64'(in_if.ready), 64'd1);

    // 1: in-order, back-to-back, consumer always ready
    chk_inorder     = 1'b1;
    n_loads         = 0;
    first_load_step = -1;
    for (int v = 'h10; v <= 'h17; v++) begin
      step(1'b1, DW'(v), 1'b1);
      check("t1_accept", 64'(last_acc), 64'd1);
    end
    drain("t1_drained");
    check("t1_count", 64'(n_loads), 64'd8);
    check("t1_latency", 64'(first_load_step - acc_cyc[64'h10]), 64'd1);
    chk_inorder = 1'b0;

    // 2: OOO, consumer stalled -> four slots plus the output register fill up
    ooo_en = 1'b1;
    repeat (2) step(1'b0, '0, 1'b0);
    n_loads = 0;
    for (int v = 1; v <= 5; v++) push("t2_accept", DW'(v), 1'b0);
    acc6 = 1'b0;
    repeat (20) begin
      step(1'b1, DW'(6), 1'b0);
      acc6 = acc6 | last_acc;
    end
    check("t2_sixth_held_off", 64'(acc6), 64'd0);
    check("t2_in_ready_low", 64'(in_if.ready), 64'd0);
    check("t2_occupancy_full", 64'(occupancy), 64'd5);
    push("t2_sixth_accept", DW'(6), 1'b1);
    drain("t2_drained");
    check("t2_count", 64'(n_loads), 64'd6);

    // 3: OOO random traffic with random backpressure
    n_loads   = 0;
    n_reorder = 0;
    sent      = 0;
    n         = 0;
    chk_res   = 1'b1;
    while (sent < 1000 && n < 20000) begin
      step(1'($urandom_range(0, 9) < 8), {32'(sent), 32'($urandom)}, 1'($urandom_range(0, 3) != 0));
      if (last_acc) sent++;
      n++;
    end
    check("t3_sent", 64'(sent), 64'd1000);
    drain("t3_drained");
    chk_res = 1'b0;
    check("t3_count", 64'(n_loads), 64'd1000);
    check("t3_reorder_seen", 64'(n_reorder > 0), 64'd1);

    // 4: request in-order while OOO entries are buffered; they drain, then order is restored
    n_loads = 0;
    for (int v = 'h100; v <= 'h102; v++) push("t4_accept_ooo", DW'(v), 1'b0);
    ooo_en = 1'b0;
    drain("t4_ooo_drained");
    check("t4_ooo_count", 64'(n_loads), 64'd3);
    step(1'b0, '0, 1'b1);
    n_loads     = 0;
    chk_inorder = 1'b1;
    for (int v = 'h110; v <= 'h113; v++) push("t4_accept_ino", DW'(v), 1'($urandom_range(0, 3) != 0));
    drain("t4_ino_drained");
    check("t4_ino_count", 64'(n_loads), 64'd4);
    chk_inorder = 1'b0;

    // 6: output held stable under backpressure
    ooo_en = 1'b1;
    repeat (2) step(1'b0, '0, 1'b0);
    push("t6_accept", DW'('h200), 1'b0);
    push("t6_accept", DW'('h201), 1'b0);
    wait_out_valid("t6_out_valid");
    saved_d   = out_if.data;
    saved_occ = occupancy;
    check("t6_occupancy", 64'(saved_occ), 64'd2);
    repeat (10) begin
      step(1'b0, '0, 1'b0);
      check("t6_data_stable", out_if.data, saved_d);
      check("t6_occ_stable", 64'(occupancy), 64'(saved_occ));
    end
    drain("t6_drained");

    // 5: reset in the middle of traffic drops everything
    for (int v = 'h300; v <= 'h303; v++) push("t5_accept", DW'(v), 1'b0);
    wait_out_valid("t5_out_valid");
    check("t5_occupancy_pre", 64'(occupancy), 64'd4);
    reset_n     = 1'b0;
    in_if.valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    outstanding.delete();
    held = 0;
    check("t5_out_valid_cleared", 64'(out_if.valid), 64'd0);
    check("t5_occupancy_cleared", 64'(occupancy), 64'd0);
    check("t5_in_ready", 64'(in_if.ready), 64'd1);
    repeat (10) begin
      step(1'b0, '0, 1'b1);
      check("t5_no_output", 64'(out_if.valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
